// File: rtl/power_sense_pkg.sv
// power_sense_pkg: CSR map, poll FSM states and event record shared by the power-sense poller.
package power_sense_pkg;
  localparam logic [1:0] CSR_STATUS  = 2'd0;
  localparam logic [1:0] CSR_EVENT   = 2'd1;
  localparam logic [1:0] CSR_CONTROL = 2'd2;
  localparam int STATUS_OVF_BIT  = 8;
  localparam int STATUS_LAST_LSB = 16;
  localparam int EVENT_CHG_LSB   = 8;
  localparam int EVENT_TS_LSB    = 16;
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int EV_DATA_W       = 6;
  localparam int EV_TS_W         = 16;
  typedef enum logic [1:0] {IDLE, READ, WAIT, CAPTURE} state_e;
  typedef struct packed {
    logic [EV_TS_W-1:0]   ts;
    logic [EV_DATA_W-1:0] changed;
    logic [EV_DATA_W-1:0] sample;
  } event_t;
  function automatic logic [31:0] event_word(event_t e);
    return (32'(e.ts) << EVENT_TS_LSB) | (32'(e.changed) << EVENT_CHG_LSB) | 32'(e.sample);
  endfunction
endpackage

// File: rtl/power_sense_event_fifo.sv
// power_sense_event_fifo: show-ahead event FIFO with occupancy count and same-cycle push/pop.
module power_sense_event_fifo
  import power_sense_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  event_t                     data_i,
  input  logic                       pop_i,
  output event_t                     head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  event_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign do_pop  = pop_i && count_q != '0;
  // A pop frees the slot a simultaneous push into a full FIFO needs.
  assign do_push = push_i && (count_q != FULL_CNT || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o  = count_q == FULL_CNT;
  assign empty_o = count_q == '0;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
endmodule

// File: rtl/power_sense_poller.sv
// power_sense_poller: polls the power-sense PIO over Avalon-MM, queues timestamped bit-change
// events for the HPS behind a CSR slave, and raises a level interrupt while events are pending.
module power_sense_poller
  import power_sense_pkg::*;
#(
  parameter int DATA_W       = 6,
  parameter int POLL_DIV     = 1000,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 8,
  parameter int TS_W         = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);
  localparam int DIV_W = $clog2(POLL_DIV);
  localparam int WC_W  = $clog2(READ_LATENCY + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [TS_W-1:0] ts_q;
  logic [DATA_W-1:0] last_q, last_d, sample, changed;
  logic en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d, bv_q, bv_d, irq_q;
  logic [31:0] rdata_q, rdata_d, status;
  logic poll, capture, push, pop, full, empty, wr_ctrl, clr_ovf;
  logic [CW-1:0] count;
  event_t ev, head;
  logic unused_ok;
  power_sense_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .reset_n, .push_i(push), .data_i(ev), .pop_i(pop),
    .head_o(head), .count_o(count), .full_o(full), .empty_o(empty)
  );
  assign avm_address  = 2'b00;
  assign avm_read     = state_q == READ;
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;
  assign unused_ok    = ^{avm_readdata[31:DATA_W], avs_writedata};
  always_comb begin
    wr_ctrl  = avs_write && avs_address == CSR_CONTROL;
    clr_ovf  = avs_write && avs_address == CSR_STATUS && avs_writedata[STATUS_OVF_BIT];
    en_d     = wr_ctrl ? avs_writedata[CTRL_EN_BIT] : en_q;
    irq_en_d = wr_ctrl ? avs_writedata[CTRL_IRQ_EN_BIT] : irq_en_q;
    poll     = en_q && div_q == '0 && state_q == IDLE;
    div_d    = (!en_q || poll) ? DIV_W'(POLL_DIV - 1) : div_q - DIV_W'(div_q != '0);
    state_d  = state_q == IDLE ? (poll ? READ : IDLE)
             : state_q == READ ? WAIT
             : state_q == WAIT ? (wcnt_q == '0 ? CAPTURE : WAIT)
             : IDLE;
    wcnt_d   = state_q == READ ? WC_W'(READ_LATENCY - 1)
             : wcnt_q - WC_W'(state_q == WAIT && wcnt_q != '0);
    capture  = state_q == CAPTURE;
    sample   = avm_readdata[DATA_W-1:0];
    changed  = sample ^ last_q;
    push     = capture && bv_q && changed != '0;
    pop      = avs_read && avs_address == CSR_EVENT;
    ev       = '{ts: EV_TS_W'(ts_q), changed: EV_DATA_W'(changed), sample: EV_DATA_W'(sample)};
    last_d   = capture ? sample : last_q;
    // Any cycle with enable low forgets the baseline, so re-enabling always re-baselines.
    bv_d     = en_d && (capture || bv_q);
    ovf_d    = (push && full && !pop) || (ovf_q && !clr_ovf);
    status   = (32'(ovf_q) << STATUS_OVF_BIT) | (32'(last_q) << STATUS_LAST_LSB)
             | (32'(count) > 32'd15 ? 32'd15 : 32'(count));
    rdata_d  = !avs_read ? '0
             : avs_address == CSR_STATUS ? status
             : avs_address == CSR_EVENT ? (empty ? '0 : event_word(head))
             : avs_address == CSR_CONTROL ? (32'(en_q) << CTRL_EN_BIT) | (32'(irq_en_q) << CTRL_IRQ_EN_BIT)
             : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      div_q    <= DIV_W'(POLL_DIV - 1);
      wcnt_q   <= '0;
      ts_q     <= '0;
      last_q   <= '0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      bv_q     <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      wcnt_q   <= wcnt_d;
      ts_q     <= ts_q + TS_W'(1);
      last_q   <= last_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      bv_q     <= bv_d;
      irq_q    <= irq_en_q && (count != '0 || ovf_q);
      rdata_q  <= rdata_d;
    end
endmodule

// File: tb/tb_power_sense_poller.sv
// tb_power_sense_poller: scenario tasks plus a cycle-level reference model of polling, events and CSRs.
module tb_power_sense_poller;
  localparam int PD = 16;
  logic clk = 0, reset_n = 0;
  logic [1:0] avm_address, avs_address = '0;
  logic avm_read, avs_read = 0, avs_write = 0, irq;
  logic [31:0] avm_readdata = '0, avs_writedata = '0, avs_readdata;
  int n_tests = 0, n_fail = 0;
  logic [5:0] pio = '0;

  power_sense_poller #(.POLL_DIV(PD)) dut (
    .clk, .reset_n, .avm_address, .avm_read, .avm_readdata, .avs_address, .avs_read,
    .avs_write, .avs_writedata, .avs_readdata, .irq
  );

  always #5 clk = ~clk;

  // Reference model: polls start every PD cycles from PD cycles after enabling, capture 3 cycles after start.
  logic [31:0] m_q[$];
  logic [5:0] m_last, m_s, m_ch;
  bit m_en, m_irq_en, m_ovf, m_bv, exp_irq, nxt_irq;
  int mcyc, next_poll, read_at, capture_at;
  logic [31:0] exp_rd;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete(); m_last = '0; m_en = 0; m_irq_en = 0; m_ovf = 0; m_bv = 0; exp_irq = 0;
      mcyc = 0; next_poll = -1; read_at = -1; capture_at = -1; exp_rd = '0;
    end else begin
      n_tests++;
      if (avm_read !== (mcyc == read_at) || (avm_read === 1'b1 && avm_address !== 2'd0)) begin
        n_fail++;
        $display("FAIL poll_strobe cyc=%0d got read=%b addr=%0d expected read=%b addr=0", mcyc, avm_read, avm_address, mcyc == read_at);
      end
      n_tests++;
      if (irq !== exp_irq) begin
        n_fail++;
        $display("FAIL irq cyc=%0d got %b expected %b", mcyc, irq, exp_irq);
      end
      exp_rd = '0;
      if (avs_read)
        case (avs_address)
          2'd0: exp_rd = (32'(m_last) << 16) | (32'(m_ovf) << 8) | 32'(m_q.size());
          2'd1: exp_rd = m_q.size() != 0 ? m_q[0] : 32'd0;
          2'd2: exp_rd = {30'd0, m_irq_en, m_en};
          default: exp_rd = '0;
        endcase
      nxt_irq = m_irq_en && (m_q.size() != 0 || m_ovf);
      if (avs_read && avs_address == 2'd1 && m_q.size() != 0) void'(m_q.pop_front());
      if (m_en && mcyc == next_poll) begin
        read_at = mcyc + 1; capture_at = mcyc + 3; next_poll = mcyc + PD;
      end
      if (avs_write && avs_address == 2'd0 && avs_writedata[8]) m_ovf = 0;
      if (mcyc == capture_at) begin
        m_s = avm_readdata[5:0];
        m_ch = m_s ^ m_last;
        if (m_bv && m_ch != 0) begin
          if (m_q.size() < 8) m_q.push_back((32'(mcyc & 16'hFFFF) << 16) | (32'(m_ch) << 8) | 32'(m_s));
          else m_ovf = 1;
        end
        m_last = m_s; m_bv = 1;
      end
      if (avs_write && avs_address == 2'd2) begin
        if (!m_en && avs_writedata[0]) next_poll = mcyc + PD;
        if (!avs_writedata[0]) next_poll = -1;
        m_en = avs_writedata[0]; m_irq_en = avs_writedata[1];
      end
      if (!m_en) m_bv = 0;
      exp_irq = nxt_irq;
      mcyc++;
    end
  end

  function automatic logic [31:0] ev_word(int ts, logic [5:0] ch, logic [5:0] s);
    return (32'(ts & 16'hFFFF) << 16) | (32'(ch) << 8) | 32'(s);
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pio(logic [5:0] v);
    pio = v;
    avm_readdata = ($urandom() & 32'hFFFF_FFC0) | 32'(v);
  endtask

  task automatic csr_write(logic [1:0] a, logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1;
    tick();
    avs_write = 0;
  endtask

  task automatic csr_read(logic [1:0] a, output logic [31:0] d, output logic [31:0] e);
    avs_address = a; avs_read = 1;
    tick();
    avs_read = 0;
    d = avs_readdata; e = exp_rd;
  endtask

  task automatic wait_poll(output int t);
    t = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (avm_read === 1'b1) begin t = mcyc; return; end
    end
    n_tests++; n_fail++;
    $display("FAIL poll_timeout got no avm_read within 64 cycles expected one");
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    n_tests++;
    if (avm_read !== 1'b0 || avm_address !== 2'd0 || irq !== 1'b0 || avs_readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got read=%b addr=%0d irq=%b rd=%h expected all 0", avm_read, avm_address, irq, avs_readdata);
    end
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), d, e);
      n_tests++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_csr%0d got %h expected 00000000", a, d); end
    end
  endtask

  task automatic test_first_poll();
    int w, t0, t1;
    logic [31:0] d, e;
    set_pio(6'h15);
    w = mcyc;
    csr_write(2'd2, 32'h3);
    wait_poll(t0);
    n_tests++;
    if (t0 - w !== PD + 1) begin n_fail++; $display("FAIL first_poll_delay got %0d expected %0d", t0 - w, PD + 1); end
    wait_poll(t1);
    n_tests++;
    if (t1 - t0 !== PD) begin n_fail++; $display("FAIL poll_period got %0d expected %0d", t1 - t0, PD); end
    tick(3);
    csr_read(2'd0, d, e);
    n_tests++;
    if (d !== 32'h0015_0000) begin n_fail++; $display("FAIL baseline_status got %h expected 00150000", d); end
  endtask

  task automatic test_single_change();
    int t;
    logic [31:0] d, e;
    set_pio(6'h14);
    wait_poll(t);
    tick(4);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got %b expected 1", irq); end
    csr_read(2'd1, d, e);
    n_tests++;
    if (d !== ev_word(t + 2, 6'h01, 6'h14)) begin
      n_fail++; $display("FAIL single_event got %h expected %h", d, ev_word(t + 2, 6'h01, 6'h14));
    end
    tick();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall got %b expected 0", irq); end
    csr_read(2'd0, d, e);
    n_tests++;
    if (d !== 32'h0014_0000) begin n_fail++; $display("FAIL single_status got %h expected 00140000", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] ev[$];
    logic [31:0] d, e;
    logic [5:0] v;
    int t;
    for (int i = 0; i < 10; i++) begin
      wait_poll(t);
      v = pio ^ 6'($urandom_range(1, 63));
      set_pio(v);
      ev.push_back(ev_word(t + 2, v ^ (i == 0 ? 6'h14 : ev[i-1][5:0]), v));
    end
    tick(3);
    csr_read(2'd0, d, e);
    n_tests++;
    if (d !== ((32'(pio) << 16) | 32'h108)) begin
      n_fail++; $display("FAIL overflow_status got %h expected %h", d, (32'(pio) << 16) | 32'h108);
    end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL overflow_irq got %b expected 1", irq); end
    for (int i = 0; i < 8; i++) begin
      csr_read(2'd1, d, e);
      n_tests++;
      if (d !== ev[i]) begin n_fail++; $display("FAIL overflow_order%0d got %h expected %h", i, d, ev[i]); end
    end
    csr_read(2'd0, d, e);
    n_tests++;
    if (d !== ((32'(pio) << 16) | 32'h100)) begin
      n_fail++; $display("FAIL overflow_sticky got %h expected %h", d, (32'(pio) << 16) | 32'h100);
    end
    csr_write(2'd0, 32'h100);
    csr_read(2'd0, d, e);
    n_tests++;
    if (d !== (32'(pio) << 16)) begin n_fail++; $display("FAIL overflow_clear got %h expected %h", d, 32'(pio) << 16); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ev[$];
    logic [31:0] d, e;
    logic [5:0] v;
    int t;
    for (int i = 0; i < 4; i++) begin
      wait_poll(t);
      v = pio ^ 6'($urandom_range(1, 63));
      ev.push_back(ev_word(t + 2, v ^ pio, v));
      set_pio(v);
      if (i == 3) begin
        tick(2);
        csr_read(2'd1, d, e);
        n_tests++;
        if (d !== ev[0]) begin n_fail++; $display("FAIL pushpop_data got %h expected %h", d, ev[0]); end
      end
    end
    csr_read(2'd0, d, e);
    n_tests++;
    if (d !== ((32'(pio) << 16) | 32'd3)) begin
      n_fail++; $display("FAIL pushpop_count got %h expected %h", d, (32'(pio) << 16) | 32'd3);
    end
    for (int i = 1; i < 4; i++) begin
      csr_read(2'd1, d, e);
      n_tests++;
      if (d !== ev[i]) begin n_fail++; $display("FAIL pushpop_drain%0d got %h expected %h", i, d, ev[i]); end
    end
  endtask

  task automatic test_disable_midpoll();
    logic [31:0] d, e;
    logic [5:0] a, b, c;
    int t, w, npoll;
    wait_poll(t);
    a = pio ^ 6'($urandom_range(1, 63));
    set_pio(a);
    tick();
    csr_write(2'd2, 32'h2);
    tick(2);
    b = a ^ 6'($urandom_range(1, 63));
    set_pio(b);
    npoll = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (avm_read === 1'b1) npoll++;
    end
    n_tests++;
    if (npoll !== 0) begin n_fail++; $display("FAIL disabled_polls got %0d expected 0", npoll); end
    csr_read(2'd0, d, e);
    n_tests++;
    if (d !== (32'(a) << 16)) begin n_fail++; $display("FAIL inflight_capture got %h expected %h", d, 32'(a) << 16); end
    w = mcyc;
    csr_write(2'd2, 32'h3);
    wait_poll(t);
    n_tests++;
    if (t - w !== PD + 1) begin n_fail++; $display("FAIL reenable_delay got %0d expected %0d", t - w, PD + 1); end
    tick(3);
    csr_read(2'd0, d, e);
    n_tests++;
    if (d !== (32'(b) << 16)) begin n_fail++; $display("FAIL rebaseline got %h expected %h", d, 32'(b) << 16); end
    wait_poll(t);
    c = b ^ 6'($urandom_range(1, 63));
    set_pio(c);
    tick(3);
    csr_read(2'd1, d, e);
    n_tests++;
    if (d !== ev_word(t + 2, b ^ c, c)) begin
      n_fail++; $display("FAIL post_reenable_event got %h expected %h", d, ev_word(t + 2, b ^ c, c));
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0, 1: tick($urandom_range(1, 6));
        2: set_pio(6'($urandom()));
        3, 4: begin
          csr_read(2'($urandom_range(0, 3)), d, e);
          n_tests++;
          if (d !== e) begin n_fail++; $display("FAIL random_read%0d got %h expected %h", i, d, e); end
        end
        5: csr_write(2'd0, $urandom() & 32'hFFFF_FEFF | (32'($urandom_range(0, 1)) << 8));
        default: csr_write($urandom_range(0, 1) ? 2'd2 : 2'd3,
                           ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1) << 1) | 32'($urandom_range(0, 3) != 0));
      endcase
    end
  endtask

  task automatic test_reset_midread();
    logic [31:0] d, e;
    int t;
    csr_write(2'd2, 32'h3);
    csr_write(2'd0, 32'h100);
    for (int i = 0; i < 9; i++) begin
      csr_read(2'd1, d, e);
    end
    wait_poll(t);
    set_pio(pio ^ 6'h2A);
    tick(4);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got %b expected 1", irq); end
    wait_poll(t);
    #2 reset_n = 0;
    #1;
    n_tests++;
    if (avm_read !== 1'b0 || irq !== 1'b0 || avs_readdata !== 32'd0) begin
      n_fail++; $display("FAIL async_reset got read=%b irq=%b rd=%h expected 0 0 0", avm_read, irq, avs_readdata);
    end
    @(posedge clk);
    #1 reset_n = 1;
    csr_read(2'd2, d, e);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_control got %h expected 00000000", d); end
    csr_read(2'd0, d, e);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_fifo got %h expected 00000000", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    reset_n = 1;
    test_reset();
    test_first_poll();
    test_single_change();
    test_overflow();
    test_back_to_back();
    test_disable_midpoll();
    test_random();
    test_reset_midread();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/power_sense_poller.md
# power_sense_poller

Avalon-MM master that periodically reads the 6-bit power-sense input PIO, which is a read-only slave with registered readdata and no waitrequest. It detects bit changes between consecutive samples and queues each change as a timestamped event in a small FIFO. An Avalon-MM slave lets the HPS pop events, read status and control polling, and an interrupt is raised while events are pending. The block sits in soc_system between the lightweight HPS bridge and the power-sense PIO.

## Interface
- DATA_W, 6, sensed input width (bits of PIO readdata used)
- POLL_DIV, 1000, clk cycles between poll starts; must be ≥ READ_LATENCY+3
- READ_LATENCY, 1, fixed PIO read latency in cycles
- FIFO_DEPTH, 8, event FIFO entries (power of two)
- TS_W, 16, timestamp counter width
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- avm_address  out  2  PIO address; always 0
- avm_read  out  1  PIO read strobe, one cycle per poll
- avm_readdata  in  32  PIO readdata; bits [DATA_W-1:0] are significant
- avs_address  in  2  CSR word address
- avs_read  in  1  CSR read strobe
- avs_write  in  1  CSR write strobe
- avs_writedata  in  32  CSR write data
- avs_readdata  out  32  CSR read data, registered
- irq  out  1  level interrupt

## Operation
- Reset values: all outputs 0; enable=0, irq_en=0, FIFO empty, overflow=0, last sample 0, baseline_valid=0, divider=POLL_DIV-1, timestamp=0.
- Timestamp: free-running TS_W counter, increments every clk, wraps to 0.
- Divider: counts down while enable=1. A poll starts when it reaches 0 and the FSM is IDLE, and it reloads to POLL_DIV-1 at that point. While enable=0 it holds at POLL_DIV-1.
- FSM states:
  - IDLE -> READ on poll start.
  - READ: avm_read=1 for exactly one cycle -> WAIT.
  - WAIT: counts READ_LATENCY cycles -> CAPTURE.
  - CAPTURE: samples avm_readdata[DATA_W-1:0] -> IDLE.
- CAPTURE when baseline_valid=0: store the sample as last, set baseline_valid. No event.
- CAPTURE when baseline_valid=1: changed = sample ^ last. If changed≠0, push {timestamp, changed, sample}. last is updated to sample in either case.
- Push while FIFO is full: the event is dropped and sticky overflow is set. last is still updated.
- Disable mid-poll: the in-flight poll completes and is captured. The FSM then stays IDLE. Clearing enable also clears baseline_valid, so re-enabling re-baselines without generating an event.
- CSR map:
  - 0 STATUS (R): [3:0] FIFO count (saturates at 15), [8] overflow, [21:16] last sample.
  - 0 STATUS (W): writedata[8]=1 clears overflow.
  - 1 EVENT (R): [5:0] sample, [13:8] changed, [31:16] timestamp. A read pops one entry. A read while empty returns 0 and does not pop.
  - 2 CONTROL (R/W): [0] enable, [1] irq_en.
  - 3: reads 0, writes ignored.
- Push and pop in the same cycle: both take effect and the count is unchanged. Push and pop on a full FIFO: the pop succeeds, the push is accepted and no overflow is flagged.
- irq = irq_en & ((count≠0) | overflow), registered.

## Timing
- avs_readdata is valid the cycle after avs_read; the FIFO pop happens in the avs_read cycle.
- Poll latency: avm_read is asserted 1 cycle after poll start, capture happens READ_LATENCY+1 cycles after avm_read, and a pushed event is visible in count on the cycle after CAPTURE.
- The captured timestamp is the counter value in the CAPTURE cycle.
- irq rises 1 cycle after the count becomes non-zero, and falls 1 cycle after the last pop or the overflow clear.
- Reset mid-operation: asynchronous return to reset values. avm_read drops immediately.

## Structure
- Package power_sense_pkg contains:
  - CSR offsets and field bit positions.
  - FSM state enum (IDLE, READ, WAIT, CAPTURE).
  - Event record typedef {ts, changed, sample}.
- Sub-module power_sense_event_fifo: a synchronous show-ahead FIFO with FIFO_DEPTH entries, a count output and simultaneous push/pop support.

## Test plan
- Enable with the PIO held at 0x15, POLL_DIV=16 -> first poll produces no event; polls repeat every 16 cycles; avm_read is 1 cycle wide with address 0.
- PIO changes from 0x15 to 0x14 -> one event with sample=0x14, changed=0x01 and the correct timestamp; irq rises when irq_en=1; an EVENT read pops it, count returns to 0 and irq falls.
- 10 changes with no reads -> count=8, overflow=1, the 8 oldest events are preserved in order; a STATUS write with bit8=1 clears overflow.
- EVENT read in the same cycle as a CAPTURE push, with count=3 -> count stays 3 and the popped data is the oldest entry.
- Clear enable during WAIT, change the PIO, then re-enable -> the in-flight sample is captured, then no polls occur while disabled, and the first poll after re-enable produces no event.
- Assert reset_n low during READ -> avm_read drops at once, irq=0, FIFO empty, CONTROL reads 0.
